// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake, registered result and compare flags.
// Define ALU_FAST_SHIFT_EN for a single-cycle barrel shifter; otherwise shifts iterate one bit per cycle.
module alu_exec_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_ctrl,
  input  logic            sub,
  input  logic            slt_unsigned,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            ltu
);
  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] result_q, result_d, calc_res;
  logic            out_valid_q, out_valid_d;
  logic            lt_q, lt_d, ltu_q, ltu_d;
  logic            lt_now, ltu_now, accept;
  logic [SW-1:0]   shamt;

  assign shamt = op_b[SW-1:0];

  // Single-cycle result; without the barrel shifter a shift only lands here when shamt is 0.
  always_comb begin
    lt_now   = $signed(op_a) < $signed(op_b);
    ltu_now  = op_a < op_b;
    calc_res = '0;
    case (alu_ctrl)
      3'b000:  calc_res = sub ? (op_a - op_b) : (op_a + op_b);
      3'b001:  calc_res = {{(XLEN-1){1'b0}}, (slt_unsigned ? ltu_now : lt_now)};
      3'b010:  calc_res = op_a & op_b;
      3'b011:  calc_res = op_a | op_b;
      3'b100:  calc_res = op_a ^ op_b;
`ifdef ALU_FAST_SHIFT_EN
      3'b101:  calc_res = $signed(op_a) >>> shamt;
      3'b110:  calc_res = op_a << shamt;
      3'b111:  calc_res = op_a >> shamt;
`endif
      default: calc_res = op_a;
    endcase
  end

`ifdef ALU_FAST_SHIFT_EN
  assign in_ready = !rst && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    result_d    = result_q;
    out_valid_d = out_valid_q;
    lt_d        = lt_q;
    ltu_d       = ltu_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      result_d    = calc_res;
      lt_d        = lt_now;
      ltu_d       = ltu_now;
      out_valid_d = 1'b1;
    end
  end
`else
  typedef enum logic {IDLE, SHIFT} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] work_q, work_d, work_step;
  logic            left_q, left_d, arith_q, arith_d;
  logic            is_shift, start_shift, shift_done;

  assign is_shift  = alu_ctrl[2] && (alu_ctrl[1:0] != 2'b00);
  assign work_step = left_q ? {work_q[XLEN-2:0], 1'b0}
                            : {(arith_q & work_q[XLEN-1]), work_q[XLEN-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_shift) state_d = SHIFT;
      SHIFT:   if (shift_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = !rst && (state_q == IDLE) && (!out_valid_q || out_ready);
    accept      = in_valid && in_ready;
    start_shift = accept && is_shift && (shamt != '0);
    shift_done  = (state_q == SHIFT) && (cnt_q == SW'(1));
  end

  // The last shift step writes the result directly, so completion costs no extra cycle.
  always_comb begin
    result_d    = result_q;
    out_valid_d = out_valid_q;
    lt_d        = lt_q;
    ltu_d       = ltu_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    arith_d     = arith_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (accept) begin
      lt_d  = lt_now;
      ltu_d = ltu_now;
      if (start_shift) begin
        work_d  = op_a;
        cnt_d   = shamt;
        left_d  = (alu_ctrl == 3'b110);
        arith_d = (alu_ctrl == 3'b101);
      end else begin
        result_d    = calc_res;
        out_valid_d = 1'b1;
      end
    end
    if (state_q == SHIFT) begin
      work_d = work_step;
      cnt_d  = cnt_q - SW'(1);
      if (shift_done) begin
        result_d    = work_step;
        out_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      work_q  <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      left_q  <= left_d;
      arith_q <= arith_d;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      lt_q        <= 1'b0;
      ltu_q       <= 1'b0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      lt_q        <= lt_d;
      ltu_q       <= ltu_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign lt        = lt_q;
  assign ltu       = ltu_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vector table plus stall and reset-abort sequences.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  typedef struct {
    logic [2:0]  ctrl;
    logic        sub;
    logic        sltu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        lt;
    logic        ltu;
    logic        zero;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  alu_ctrl = 3'b000;
  logic        sub = 1'b0;
  logic        slt_unsigned = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, lt, ltu;

  int checks = 0;
  int failures = 0;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .sub(sub), .slt_unsigned(slt_unsigned),
    .op_a(op_a), .op_b(op_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .lt(lt), .ltu(ltu)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int expLatency(input vec_t v);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    logic [4:0] sh;
    sh = v.b[4:0];
    if (v.ctrl[2] && (v.ctrl[1:0] != 2'b00) && (sh != 5'd0)) return 1 + int'(sh);
    return 1;
`endif
  endfunction

  // Presents one op, scrambles inputs after accept, then waits (bounded) for the result.
  task automatic applyStimulus(input vec_t v, input string tag, output int lat, output int busy);
    alu_ctrl     = v.ctrl;
    sub          = v.sub;
    slt_unsigned = v.sltu;
    op_a         = v.a;
    op_b         = v.b;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid     = 1'b0;
    op_a         = ~v.a;
    op_b         = ~v.b;
    alu_ctrl     = v.ctrl ^ 3'b011;
    sub          = ~v.sub;
    slt_unsigned = ~v.sltu;
    lat  = 1;
    busy = 0;
    while (!out_valid && lat < 40) begin
      if (!in_ready) busy++;
      step();
      lat++;
    end
  endtask

  initial begin
    vec_t vecs[16];
    int   lat, busy, seen;

    vecs[0]  = '{3'b000, 1'b1, 1'b0, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'b001, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{3'b010, 1'b1, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'b011, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FFF0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b100, 1'b0, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b000, 1'b1, 1'b0, 32'h0000_1234, 32'h0000_1234, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{3'b101, 1'b0, 1'b0, 32'h8000_0000, 32'd4,         32'hF800_0000, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{3'b110, 1'b0, 1'b0, 32'h0000_0001, 32'd31,        32'h8000_0000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{3'b111, 1'b0, 1'b0, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b110, 1'b0, 1'b0, 32'h0000_ABCD, 32'd0,         32'h0000_ABCD, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b111, 1'b0, 1'b0, 32'hFFFF_0000, 32'd16,        32'h0000_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{3'b101, 1'b0, 1'b0, 32'h7000_0000, 32'd28,        32'h0000_0007, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{3'b001, 1'b0, 1'b0, 32'd3,         32'h8000_0000, 32'h0000_0000, 1'b0, 1'b1, 1'b1};
    vecs[15] = '{3'b101, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd1,         32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0};

    // Reset state, with rst still high
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  32'(in_ready),  32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_result",    result,         32'd0);
    checkOutput("rst_zero",      32'(zero),      32'd1);
    checkOutput("rst_lt",        32'(lt),        32'd0);
    checkOutput("rst_ltu",       32'(ltu),       32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 16; i++) begin
      string tag;
      tag = $sformatf("v%0d", i);
      applyStimulus(vecs[i], tag, lat, busy);
      checkOutput({tag, "_latency"}, 32'(lat),     32'(expLatency(vecs[i])));
      checkOutput({tag, "_busy"},    32'(busy),    32'(expLatency(vecs[i]) - 1));
      checkOutput({tag, "_valid"},   32'(out_valid), 32'd1);
      checkOutput({tag, "_result"},  result,       vecs[i].res);
      checkOutput({tag, "_zero"},    32'(zero),    32'(vecs[i].zero));
      checkOutput({tag, "_lt"},      32'(lt),      32'(vecs[i].lt));
      checkOutput({tag, "_ltu"},     32'(ltu),     32'(vecs[i].ltu));
    end

    // Drain, then stall the consumer after an and and check everything holds
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    alu_ctrl = 3'b010; sub = 1'b0; op_a = 32'h0000_F0F0; op_b = 32'h0000_0FF0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    alu_ctrl = 3'b100; op_a = 32'd1; op_b = 32'd2;
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("stall%0d_valid", c),    32'(out_valid), 32'd1);
      checkOutput($sformatf("stall%0d_result", c),   result,         32'h0000_00F0);
      checkOutput($sformatf("stall%0d_lt", c),       32'(lt),        32'd0);
      checkOutput($sformatf("stall%0d_ltu", c),      32'(ltu),       32'd0);
      checkOutput($sformatf("stall%0d_in_ready", c), 32'(in_ready),  32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    checkOutput("b2b_valid",  32'(out_valid), 32'd1);
    checkOutput("b2b_result", result,         32'h0000_0003);
    checkOutput("b2b_lt",     32'(lt),        32'd1);
    checkOutput("b2b_ltu",    32'(ltu),       32'd1);
    step();
    checkOutput("b2b_drain_valid", 32'(out_valid), 32'd0);

    // Reset in the middle of a long left shift
    alu_ctrl = 3'b110; op_a = 32'd1; op_b = 32'd31;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    checkOutput("abort_valid",    32'(out_valid), 32'd0);
    checkOutput("abort_result",   result,         32'd0);
    checkOutput("abort_zero",     32'(zero),      32'd1);
    checkOutput("abort_lt",       32'(lt),        32'd0);
    checkOutput("abort_ltu",      32'(ltu),       32'd0);
    checkOutput("abort_in_ready", 32'(in_ready),  32'd0);
    #1;
    rst = 1'b0;
    seen = 0;
    repeat (40) begin
      step();
      if (out_valid) seen++;
    end
    checkOutput("abort_no_result", 32'(seen),     32'd0);
    checkOutput("abort_ready",     32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
